// File: rtl/drv_led.sv
// LED pin driver: steady off/on, continuous blink and counted burst, all with PWM brightness.
// Board polarity is folded into the registered pin so the rest of the logic works in "lit" terms.
module drv_led #(
    parameter int unsigned p_scale    = 5,
    parameter string       p_mode     = "activehigh",
    parameter int unsigned p_bright_w = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_mode,
    input  logic [3:0]            i_cmd_count,
    input  logic [7:0]            i_cmd_period,
    input  logic [p_bright_w-1:0] i_cmd_bright,
    output logic                  o_drv_led,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam logic lp_active_low = (p_mode == "activelow");

    typedef enum logic [1:0] {S_OFF, S_ON, S_BLINK, S_BURST} state_t;

    state_t                state_q, state_d;
    logic [p_scale-1:0]    presc_q, presc_d;
    logic [p_bright_w-1:0] pwm_q, pwm_d;
    logic [p_bright_w-1:0] bright_q, bright_d;
    logic [7:0]            period_q, period_d;
    logic [7:0]            pcnt_q, pcnt_d;
    logic [3:0]            bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic                  done_q, done_d;
    logic                  led_q, led_d;

    logic       accept;
    logic       tick;
    logic       phase_end;
    logic       pwm_on;
    logic [7:0] cmd_period_eff;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc_q  <= '0;
            pwm_q    <= '0;
            bright_q <= '0;
            period_q <= '0;
            pcnt_q   <= '0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
            done_q   <= 1'b0;
            led_q    <= lp_active_low;
        end else begin
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            bright_q <= bright_d;
            period_q <= period_d;
            pcnt_q   <= pcnt_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            done_q   <= done_d;
            led_q    <= led_d;
        end
    end

    always_comb begin
        cmd_period_eff = (i_cmd_period == 8'd0) ? 8'd1 : i_cmd_period;
        tick           = (presc_q == '1);
        phase_end      = (pcnt_q <= 8'd1);

        state_d  = state_q;
        phase_d  = phase_q;
        pcnt_d   = pcnt_q;
        bcnt_d   = bcnt_q;
        period_d = period_q;
        bright_d = bright_q;
        done_d   = 1'b0;
        presc_d  = presc_q + 1'b1;
        pwm_d    = pwm_q + 1'b1;

        if (accept) begin
            presc_d  = '0;
            period_d = cmd_period_eff;
            pcnt_d   = cmd_period_eff;
            bcnt_d   = i_cmd_count;
            bright_d = i_cmd_bright;
            case (i_cmd_mode)
                2'd0: begin
                    state_d = S_OFF;
                    phase_d = 1'b0;
                end
                2'd1: begin
                    state_d = S_ON;
                    phase_d = 1'b1;
                end
                2'd2: begin
                    state_d = S_BLINK;
                    phase_d = 1'b1;
                end
                default: begin
                    // An empty burst completes on the accept edge itself.
                    if (i_cmd_count == 4'd0) begin
                        state_d = S_OFF;
                        phase_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        phase_d = 1'b1;
                    end
                end
            endcase
        end else if (tick && (state_q == S_BLINK || state_q == S_BURST)) begin
            if (phase_end) begin
                pcnt_d = period_q;
                if (state_q == S_BLINK) begin
                    phase_d = ~phase_q;
                end else if (phase_q) begin
                    phase_d = 1'b0;
                end else if (bcnt_q <= 4'd1) begin
                    state_d = S_OFF;
                    bcnt_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    bcnt_d  = bcnt_q - 1'b1;
                    phase_d = 1'b1;
                end
            end else begin
                pcnt_d = pcnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        o_cmd_ready = (state_q != S_BURST);
        o_busy      = (state_q == S_BURST);
        accept      = i_cmd_valid & o_cmd_ready;
        pwm_on      = (bright_q == '1) | (pwm_q < bright_q);
        led_d       = (phase_q & pwm_on) ^ lp_active_low;
        o_done      = done_q;
        o_drv_led   = led_q;
    end

endmodule

// File: tb/tb_drv_led.sv
// Bench for drv_led: an active-high and an active-low instance share one stimulus stream and
// are compared every cycle against a time-based reference model, plus vector tables and corner sequences.
module tb_drv_led;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [1:0] mode;
    logic [3:0] count;
    logic [7:0] period;
    logic [3:0] bright;

    logic ready_h, led_h, busy_h, done_h;
    logic ready_l, led_l, busy_l, done_l;

    always #5 clk = ~clk;

    drv_led #(.p_scale(2), .p_mode("activehigh"), .p_bright_w(4)) u_dut_h (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(ready_h),
        .i_cmd_mode(mode), .i_cmd_count(count), .i_cmd_period(period), .i_cmd_bright(bright),
        .o_drv_led(led_h), .o_busy(busy_h), .o_done(done_h)
    );

    drv_led #(.p_scale(2), .p_mode("activelow"), .p_bright_w(4)) u_dut_l (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(ready_l),
        .i_cmd_mode(mode), .i_cmd_count(count), .i_cmd_period(period), .i_cmd_bright(bright),
        .o_drv_led(led_l), .o_busy(busy_l), .o_done(done_l)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: state is described by the last accepted command and the edge it was accepted on.
    int   n;
    int   m_mode, m_t0, m_len, m_cnt, m_bright;
    logic exp_phase, exp_busy, exp_done, exp_pin;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] count;
        logic [7:0] period;
        logic [3:0] bright;
        int         win;
        int         exp_hi;
        int         exp_busy;
        int         exp_done;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n         = 0;
        m_mode    = 0;
        m_t0      = 0;
        m_len     = 4;
        m_cnt     = 0;
        m_bright  = 0;
        exp_phase = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_pin   = 1'b0;
    endtask

    task automatic step();
        logic lit_prev;
        logic acc;
        int   k;
        int   span;
        lit_prev = exp_phase && ((m_bright == 15) || ((n % 16) < m_bright));
        acc      = valid && !exp_busy;
        @(posedge clk);
        n++;
        if (acc) begin
            m_mode   = int'(mode);
            m_t0     = n;
            m_len    = ((period == 8'd0) ? 1 : int'(period)) * 4;
            m_cnt    = int'(count);
            m_bright = int'(bright);
        end
        k         = n - m_t0;
        span      = m_cnt * 2 * m_len;
        exp_phase = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        case (m_mode)
            1: exp_phase = 1'b1;
            2: exp_phase = ((k / m_len) % 2) == 0;
            3: begin
                exp_busy  = (k < span);
                exp_phase = exp_busy && (((k / m_len) % 2) == 0);
                exp_done  = (k == span);
            end
            default: ;
        endcase
        exp_pin = lit_prev;
        #1;
        check("pin_h", led_h, exp_pin);
        check("pin_l", led_l, !exp_pin);
        check("ready_h", ready_h, !exp_busy);
        check("busy_h", busy_h, exp_busy);
        check("done_h", done_h, exp_done);
        check("ready_l", ready_l, !exp_busy);
        check("busy_l", busy_l, exp_busy);
        check("done_l", done_l, exp_done);
    endtask

    task automatic set_cmd(input logic [1:0] md, input logic [3:0] ct, input logic [7:0] pd, input logic [3:0] br);
        mode   = md;
        count  = ct;
        period = pd;
        bright = br;
        valid  = 1'b1;
    endtask

    task automatic run(input int w, input logic keep, output int hi, output int lo_l, output int bz, output int dn);
        hi   = 0;
        lo_l = 0;
        bz   = 0;
        dn   = 0;
        for (int i = 0; i < w; i++) begin
            step();
            if (!keep) valid = 1'b0;
            if (led_h === 1'b1) hi++;
            if (led_l === 1'b0) lo_l++;
            if (busy_h === 1'b1) bz++;
            if (done_h === 1'b1) dn++;
        end
    endtask

    task automatic go_idle();
        int hi, lo, bz, dn;
        set_cmd(2'd0, 4'd0, 8'd0, 4'd0);
        run(4, 1'b0, hi, lo, bz, dn);
    endtask

    initial begin
        int hi, lo, bz, dn;
        int s_hi, s_bz, s_dn;

        vecs[0] = '{2'd1, 4'd0,  8'd0, 4'd15,  32, 32,   0, 0};
        vecs[1] = '{2'd1, 4'd0,  8'd0, 4'd4,   32,  8,   0, 0};
        vecs[2] = '{2'd2, 4'd0,  8'd3, 4'd15,  48, 24,   0, 0};
        vecs[3] = '{2'd3, 4'd2,  8'd3, 4'd15,  60, 24,  48, 1};
        vecs[4] = '{2'd3, 4'd0,  8'd5, 4'd15,  20,  0,   0, 1};
        vecs[5] = '{2'd3, 4'd1,  8'd0, 4'd15,  20,  4,   8, 1};
        vecs[6] = '{2'd2, 4'd0,  8'd0, 4'd15,  32, 16,   0, 0};
        vecs[7] = '{2'd3, 4'd3,  8'd1, 4'd0,   40,  0,  24, 1};
        vecs[8] = '{2'd0, 4'd0,  8'd0, 4'd15,  16,  0,   0, 0};
        vecs[9] = '{2'd3, 4'd15, 8'd1, 4'd15, 130, 60, 120, 1};

        rst    = 1'b1;
        valid  = 1'b0;
        mode   = '0;
        count  = '0;
        period = '0;
        bright = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pin_h", led_h, 1'b0);
        check("rst_pin_l", led_l, 1'b1);
        check("rst_ready", ready_h, 1'b1);
        check("rst_busy", busy_h, 1'b0);
        check("rst_done", done_h, 1'b0);
        #3;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            go_idle();
            set_cmd(vecs[i].mode, vecs[i].count, vecs[i].period, vecs[i].bright);
            run(vecs[i].win + 1, 1'b0, hi, lo, bz, dn);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo_l", i), lo, vecs[i].exp_hi);
            check($sformatf("vec%0d_busy", i), bz, vecs[i].exp_busy);
            check($sformatf("vec%0d_done", i), dn, vecs[i].exp_done);
        end

        // Blink interrupted by an off command: pin drops one clock after the accept.
        go_idle();
        set_cmd(2'd2, 4'd0, 8'd3, 4'd15);
        run(6, 1'b0, hi, lo, bz, dn);
        set_cmd(2'd0, 4'd0, 8'd0, 4'd15);
        step();
        valid = 1'b0;
        check("blink_pre_off_pin", led_h, 1'b1);
        step();
        check("blink_off_pin", led_h, 1'b0);

        // Commands presented mid-burst are dropped and the burst pattern is unchanged.
        go_idle();
        set_cmd(2'd3, 4'd2, 8'd3, 4'd15);
        run(20, 1'b0, hi, lo, bz, dn);
        s_hi = hi; s_bz = bz; s_dn = dn;
        set_cmd(2'd1, 4'd0, 8'd0, 4'd15);
        run(10, 1'b1, hi, lo, bz, dn);
        s_hi += hi; s_bz += bz; s_dn += dn;
        valid = 1'b0;
        run(31, 1'b0, hi, lo, bz, dn);
        s_hi += hi; s_bz += bz; s_dn += dn;
        check("midburst_hi", s_hi, 24);
        check("midburst_busy", s_bz, 48);
        check("midburst_done", s_dn, 1);

        // Active-low steady on.
        go_idle();
        set_cmd(2'd1, 4'd0, 8'd0, 4'd15);
        run(5, 1'b0, hi, lo, bz, dn);
        check("al_on_pin_l", led_l, 1'b0);
        check("al_on_pin_h", led_h, 1'b1);

        // Asynchronous reset in the middle of a lit burst phase.
        go_idle();
        set_cmd(2'd3, 4'd2, 8'd3, 4'd15);
        run(10, 1'b0, hi, lo, bz, dn);
        check("pre_rst_pin_l", led_l, 1'b0);
        rst = 1'b1;
        #1;
        check("async_rst_pin_h", led_h, 1'b0);
        check("async_rst_pin_l", led_l, 1'b1);
        check("async_rst_ready", ready_h, 1'b1);
        check("async_rst_busy", busy_h, 1'b0);
        check("async_rst_done", done_h, 1'b0);
        #3;
        rst = 1'b0;
        model_reset();
        run(60, 1'b0, hi, lo, bz, dn);
        check("post_rst_done", dn, 0);
        check("post_rst_hi", hi, 0);

        // Randomized command stream against the model.
        go_idle();
        for (int i = 0; i < 2000; i++) begin
            valid  = ($urandom_range(0, 3) == 0);
            mode   = 2'($urandom_range(0, 3));
            count  = 4'($urandom_range(0, 3));
            period = 8'($urandom_range(0, 4));
            bright = 4'($urandom_range(0, 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
